// File: rtl/snake_game_ctrl.sv
// Snake game controller: start/pause/over FSM, move-tick timer, direction commit, move counter.
// Optional speed-up of the move rate every 16 moves is enabled with `define SNAKE_SPEEDUP_EN.
module snake_game_ctrl #(
  parameter int TICK_DIV  = 12500000,
  parameter int TICK_STEP = 500000,
  parameter int TICK_MIN  = 3125000
) (
  input  logic       clk50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] dir_req,
  input  logic       dir_req_valid,
  input  logic       game_over,
  output logic       move_tick,
  output logic [1:0] direction,
  output logic [1:0] state,
  output logic       dp_init_n,
  output logic [7:0] moves
);

  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] DIV_W = CNT_W'(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             start_q, pause_q;
  logic             arm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_tick_q, move_tick_d;
  logic [1:0]       direction_q, direction_d;
  logic [1:0]       pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic [7:0]       moves_q, moves_d;
  logic             dp_init_n_q, dp_init_n_d;

  logic             start_edge, pause_edge;
  logic             launch, tick_fire, dir_acc;
  logic [CNT_W-1:0] thr_m1;

  // arm_q masks the first cycle after reset so a key held through release is not an edge.
  assign start_edge = arm_q & start & ~start_q;
  assign pause_edge = arm_q & pause & ~pause_q;
  assign launch     = (state_q == ST_IDLE) && start_edge;
  assign tick_fire  = (state_q == ST_PLAY) && !game_over && (cnt_q == thr_m1);
  assign dir_acc    = ((state_q == ST_PLAY) || (state_q == ST_PAUSE)) &&
                      dir_req_valid && (dir_req != ~direction_q);

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(TICK_STEP);
  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(TICK_MIN);

  logic [CNT_W-1:0] thr_q, thr_d;

  always_comb begin
    thr_d = thr_q;
    if (launch) begin
      thr_d = DIV_W;
    end else if (tick_fire && (moves_q != 8'hff) && (moves_q[3:0] == 4'hf)) begin
      thr_d = (thr_q >= MIN_W + STEP_W) ? (thr_q - STEP_W) : MIN_W;
    end
  end

  always_ff @(posedge clk50) begin
    if (!resetn) begin
      thr_q <= DIV_W;
    end else begin
      thr_q <= thr_d;
    end
  end

  assign thr_m1 = thr_q - CNT_W'(1);
`else
  assign thr_m1 = DIV_W - CNT_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (game_over)       state_d = ST_OVER;
        else if (pause_edge) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_edge) state_d = ST_PLAY;
      ST_OVER:  if (start_edge) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    case (state_q)
      ST_PLAY:  cnt_d = (game_over || tick_fire) ? '0 : cnt_q + CNT_W'(1);
      ST_PAUSE: cnt_d = cnt_q;
      default:  cnt_d = '0;
    endcase
  end

  always_comb begin
    move_tick_d = tick_fire;
    dp_init_n_d = (state_d != ST_IDLE);
    moves_d     = moves_q;
    if (launch) begin
      moves_d = '0;
    end else if (tick_fire && (moves_q != 8'hff)) begin
      moves_d = moves_q + 8'd1;
    end
  end

  // A request in the commit cycle is judged against the old direction and waits for the next tick.
  always_comb begin
    direction_d = direction_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (launch) begin
      direction_d = 2'd3;
      pend_d      = 2'd0;
      pend_flag_d = 1'b0;
    end else begin
      if (tick_fire) begin
        if (pend_flag_q) direction_d = pend_q;
        pend_flag_d = 1'b0;
      end
      if (dir_acc) begin
        pend_d      = dir_req;
        pend_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      arm_q       <= 1'b0;
      cnt_q       <= '0;
      move_tick_q <= 1'b0;
      direction_q <= 2'd3;
      pend_flag_q <= 1'b0;
      moves_q     <= '0;
      dp_init_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      pause_q     <= pause;
      arm_q       <= 1'b1;
      cnt_q       <= cnt_d;
      move_tick_q <= move_tick_d;
      direction_q <= direction_d;
      pend_flag_q <= pend_flag_d;
      moves_q     <= moves_d;
      dp_init_n_q <= dp_init_n_d;
    end
  end

  always_ff @(posedge clk50) begin
    pend_q <= pend_d;
  end

  assign move_tick = move_tick_q;
  assign direction = direction_q;
  assign state     = state_q;
  assign dp_init_n = dp_init_n_q;
  assign moves     = moves_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=4, TICK_STEP=1, TICK_MIN=2.
module tb_snake_game_ctrl;

  logic       clk50 = 1'b0;
  logic       resetn;
  logic       start;
  logic       pause;
  logic [1:0] dir_req;
  logic       dir_req_valid;
  logic       game_over;
  logic       move_tick;
  logic [1:0] direction;
  logic [1:0] state;
  logic       dp_init_n;
  logic [7:0] moves;

  int checks = 0;
  int errors = 0;

`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  snake_game_ctrl #(.TICK_DIV(4), .TICK_STEP(1), .TICK_MIN(2)) dut (
    .clk50(clk50), .resetn(resetn), .start(start), .pause(pause),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid), .game_over(game_over),
    .move_tick(move_tick), .direction(direction), .state(state),
    .dp_init_n(dp_init_n), .moves(moves)
  );

  always #5 clk50 = ~clk50;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  // Cycles until move_tick is seen; -1 when it never arrives within the budget.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (move_tick) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int exp_period(input int m);
    if (!SPEEDUP) return 4;
    if (m <= 16) return 4;
    if (m <= 32) return 3;
    return 2;
  endfunction

  initial begin
    int n;
    int ticks;
    resetn = 1'b0; start = 1'b0; pause = 1'b0;
    dir_req = 2'd0; dir_req_valid = 1'b0; game_over = 1'b0;
    step(2);
    chk("rst_state", state, 0);
    chk("rst_dp_init_n", dp_init_n, 0);
    chk("rst_move_tick", move_tick, 0);
    chk("rst_direction", direction, 3);
    chk("rst_moves", moves, 0);

    // start from IDLE
    resetn = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    chk("start_state", state, 1);
    chk("start_dp_init_n", dp_init_n, 1);
    chk("start_move_tick", move_tick, 0);
    wait_tick(n);
    chk("tick1_period", n, 4);
    chk("tick1_moves", moves, 1);
    wait_tick(n);
    chk("tick2_period", n, 4);
    chk("tick2_moves", moves, 2);

    // reversal rejected, later request overwrites pending
    dir_req = 2'd0; dir_req_valid = 1'b1;
    step(1);
    chk("rev_rejected_dir", direction, 3);
    dir_req = 2'd1;
    step(1);
    dir_req = 2'd2;
    step(1);
    dir_req_valid = 1'b0;
    chk("pending_not_committed", direction, 3);
    wait_tick(n);
    chk("dir_tick_period", n, 1);
    chk("dir_commit", direction, 2);

    // request in the commit cycle is held for the following tick
    step(3);
    dir_req = 2'd0; dir_req_valid = 1'b1;
    step(1);
    dir_req_valid = 1'b0;
    chk("same_cycle_tick", move_tick, 1);
    chk("same_cycle_dir_old", direction, 2);
    wait_tick(n);
    chk("held_req_period", n, 4);
    chk("held_req_dir", direction, 0);
    chk("moves_after_dir", moves, 5);

    // pause with counter at 2, game_over ignored while paused
    step(1);
    pause = 1'b1;
    step(1);
    chk("pause_state", state, 2);
    game_over = 1'b1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (move_tick) ticks++;
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_ignores_over", state, 2);
    game_over = 1'b0;
    pause = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
    chk("resume_state", state, 1);
    wait_tick(n);
    chk("resume_period", n, 2);
    chk("resume_moves", moves, 6);

    // game_over on the tick cycle wins
    step(3);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    chk("over_no_tick", move_tick, 0);
    chk("over_state", state, 3);
    chk("over_moves", moves, 6);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("over_to_idle", state, 0);
    chk("idle_dp_init_n", dp_init_n, 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("restart_state", state, 1);
    chk("restart_moves", moves, 0);
    chk("restart_dir", direction, 3);

    // reset mid-game with start held high
    step(5);
    chk("pre_reset_moves", moves, 1);
    resetn = 1'b0;
    step(1);
    chk("midrst_state", state, 0);
    chk("midrst_moves", moves, 0);
    chk("midrst_move_tick", move_tick, 0);
    chk("midrst_dir", direction, 3);
    chk("midrst_dp_init_n", dp_init_n, 0);
    resetn = 1'b1;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (move_tick) ticks++;
    end
    chk("held_start_no_play", state, 0);
    chk("held_start_no_tick", ticks, 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("replay_state", state, 1);

    // tick period per move, with or without speed-up
    for (int m = 1; m <= 40; m++) begin
      wait_tick(n);
      chk($sformatf("period_m%0d", m), n, exp_period(m));
    end
    chk("moves_40", moves, 40);
    for (int m = 41; m <= 270; m++) begin
      wait_tick(n);
    end
    chk("sat_last_period", n, exp_period(270));
    chk("moves_saturated", moves, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
